// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching CPU: opcode encodings and sequencer states.
package cpu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OPC_ADD  = 3'd0;
  localparam logic [OPC_W-1:0] OPC_ADDI = 3'd1;
  localparam logic [OPC_W-1:0] OPC_SUB  = 3'd2;
  localparam logic [OPC_W-1:0] OPC_LW   = 3'd3;
  localparam logic [OPC_W-1:0] OPC_SW   = 3'd4;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 3'd5;
  localparam logic [OPC_W-1:0] OPC_NOP  = 3'd6;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'd7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_BRWAIT = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory: single write port, synchronous read with one cycle of latency.
module prog_mem #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  // Write-first: a read of the address being written returns the new word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: program memory, PC, fetch and valid/ready issue to the decoder.
// Optional performance counters (retired, stall_cycles) are built when INSTR_SEQ_PERF_EN is defined.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16,
  parameter int OFF_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  pc,
  input  logic               branch_taken,
  output logic               halted,
  output logic               busy
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [15:0]        retired,
  output logic [15:0]        stall_cycles
`endif
);

  logic [2:0]               state, state_nxt;
  logic [ADDR_W-1:0]        pc_nxt;
  logic [ADDR_W-1:0]        br_off;
  logic [INSTR_W-1:0]       rdata;
  logic [OPC_W-1:0]         rdata_opc;
  logic signed [OFF_W-1:0]  off;
  logic                     idle_like;
  logic                     go;
  logic                     hs;
  logic                     mem_we;

  assign idle_like = (state == ST_IDLE) || (state == ST_HALT);
  assign go        = idle_like && start;
  assign hs        = instr_valid && instr_ready;
  assign mem_we    = idle_like && prog_we;
  assign busy      = !idle_like;
  assign opcode    = instr[INSTR_W-1 -: OPC_W];
  assign rdata_opc = rdata[INSTR_W-1 -: OPC_W];
  assign off       = instr[OFF_W-1:0];
  assign br_off    = ADDR_W'(off);

  // The RAM is addressed with next-cycle PC so the word is ready during FETCH.
  prog_mem #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_nxt),
    .rdata (rdata)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_nxt = (rdata_opc == OPC_HALT) ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          if (opcode == OPC_BEQ) begin
            state_nxt = ST_BRWAIT;
          end else begin
            pc_nxt    = pc + ADDR_W'(1);
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_BRWAIT: begin
        pc_nxt    = branch_taken ? (pc + br_off) : (pc + ADDR_W'(1));
        state_nxt = ST_FETCH;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == ST_FETCH) begin
        instr       <= rdata;
        instr_valid <= (rdata_opc != OPC_HALT);
        halted      <= (rdata_opc == OPC_HALT);
      end
      if (hs) begin
        instr_valid <= 1'b0;
      end
      if (go) begin
        halted <= 1'b0;
      end
    end
  end

`ifdef INSTR_SEQ_PERF_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset || go) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (hs && (retired != 16'hFFFF)) begin
        retired <= retired + 16'd1;
      end
      if (instr_valid && !instr_ready && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level interpreter predicts every issue.
module tb_instr_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [4:0]  pc;
  logic        branch_taken;
  logic        halted;
  logic        busy;
`ifdef INSTR_SEQ_PERF_EN
  logic [15:0] retired;
  logic [15:0] stall_cycles;
`endif

  typedef struct {
    logic [15:0] w;
    int          pc;
  } issue_t;

  issue_t      expq[$];
  bit          br_dec[$];
  bit          plan[$];
  logic [15:0] model_mem [32];
  int          vectors = 0;
  int          miscompares = 0;
  int          ready_pct = 100;
  int          stall_req = 0;
  bit          pending_branch = 0;
  int          exp_issues = 0;
  int          exp_hpc = 0;

  instr_sequencer #(.ADDR_W(5), .INSTR_W(16), .OFF_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .opcode       (opcode),
    .pc           (pc),
    .branch_taken (branch_taken),
    .halted       (halted),
    .busy         (busy)
`ifdef INSTR_SEQ_PERF_EN
    ,
    .retired      (retired),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Interpret the program from address 0 until HALT, queuing every expected issue.
  task automatic run_model();
    int p = 0;
    int n = 0;
    logic [15:0] w;
    int soff;
    bit d;
    br_dec.delete();
    while (n < 500) begin
      w = model_mem[p];
      if (w[15:13] == 3'd7) break;
      expq.push_back('{w: w, pc: p});
      n++;
      if (w[15:13] == 3'd5) begin
        d = (plan.size() > 0) ? plan.pop_front() : 1'($urandom_range(1));
        br_dec.push_back(d);
        soff = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
        p = d ? (p + soff + 32) % 32 : (p + 1) % 32;
      end else begin
        p = (p + 1) % 32;
      end
    end
    exp_issues = n;
    exp_hpc    = p;
  endtask

  task automatic write_word(input int a, input logic [15:0] d, input bit accepted);
    prog_we   = 1'b1;
    prog_addr = 5'(a);
    prog_data = d;
    tick();
    prog_we = 1'b0;
    if (accepted) model_mem[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(halted === 1'b1 && expq.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: actual pending=%0d halted=%b, required halt within %0d cycles", tag, expq.size(), halted, budget);
      expq.delete();
    end
    checkOutput({tag, "_halted"}, 32'(halted), 32'd1);
    checkOutput({tag, "_halt_pc"}, 32'(pc), 32'(exp_hpc));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd0);
`ifdef INSTR_SEQ_PERF_EN
    checkOutput({tag, "_retired"}, 32'(retired), 32'(exp_issues));
`endif
  endtask

  task automatic applyStimulus(input string tag, input int budget);
    run_model();
    pulse_start();
    wait_done(tag, budget);
  endtask

  // Monitor: every cycle the DUT offers an instruction must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && instr_valid) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_issue: actual pc=%0d instr=%h, expected no issue", pc, instr);
      end else begin
        checkOutput("issue_pc", 32'(pc), 32'(expq[0].pc));
        checkOutput("issue_instr", 32'(instr), 32'(expq[0].w));
        checkOutput("issue_opcode", 32'(opcode), 32'(expq[0].w[15:13]));
        if (instr_ready) begin
          if (expq[0].w[15:13] == 3'd5) pending_branch = 1'b1;
          void'(expq.pop_front());
        end
      end
    end
  end

  // Responder: drives ready and the branch outcome one cycle after a branch handshake.
  initial begin
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    forever begin
      tick();
      if (pending_branch) begin
        branch_taken   = (br_dec.size() > 0) ? br_dec.pop_front() : 1'b0;
        pending_branch = 1'b0;
      end else begin
        branch_taken = 1'($urandom_range(1));
      end
      if (stall_req > 0 && instr_valid) begin
        instr_ready = 1'b0;
        stall_req--;
      end else begin
        instr_ready = (int'($urandom_range(99)) < ready_pct);
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] w;
    int len;
    int n;
    reset     = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    checkOutput("reset_valid", 32'(instr_valid), 32'd0);
    checkOutput("reset_pc", 32'(pc), 32'd0);
    checkOutput("reset_instr", 32'(instr), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    for (int a = 0; a < 32; a++) write_word(a, {3'd6, 13'(a)}, 1'b1);

    // Straight-line program, then the same with a 4-cycle stall on the first issue.
    write_word(0, {3'd1, 13'h0A5}, 1'b1);
    write_word(1, {3'd2, 13'h133}, 1'b1);
    write_word(2, {3'd7, 13'h000}, 1'b1);
    applyStimulus("linear", 100);
`ifdef INSTR_SEQ_PERF_EN
    checkOutput("linear_stalls", 32'(stall_cycles), 32'd0);
`endif
    stall_req = 4;
    applyStimulus("stalled", 100);
`ifdef INSTR_SEQ_PERF_EN
    checkOutput("stalled_stalls", 32'(stall_cycles), 32'd4);
`endif

    // Backward branch at 3 (offset -3): taken once, then not taken.
    write_word(0, {3'd6, 13'h011}, 1'b1);
    write_word(1, {3'd0, 13'h022}, 1'b1);
    write_word(2, {3'd3, 13'h033}, 1'b1);
    write_word(3, {3'd5, 8'h12, 5'b11101}, 1'b1);
    write_word(4, {3'd7, 13'h000}, 1'b1);
    plan.push_back(1'b1);
    plan.push_back(1'b0);
    applyStimulus("branch_back", 200);

    // Wrap in both directions through address 31.
    write_word(0, {3'd5, 8'h00, 5'h1F}, 1'b1);
    write_word(1, {3'd4, 13'h044}, 1'b1);
    write_word(2, {3'd5, 8'h00, 5'h1D}, 1'b1);
    write_word(3, {3'd7, 13'h000}, 1'b1);
    write_word(31, {3'd5, 8'h00, 5'd2}, 1'b1);
    plan.push_back(1'b1);
    plan.push_back(1'b1);
    plan.push_back(1'b0);
    applyStimulus("wrap_branch", 200);

    write_word(31, {3'd1, 13'h055}, 1'b1);
    write_word(1, {3'd7, 13'h000}, 1'b1);
    plan.push_back(1'b1);
    plan.push_back(1'b0);
    applyStimulus("wrap_linear", 200);

    // Reset while an instruction is held in ISSUE, then rerun the same program.
    write_word(0, {3'd1, 13'h0A5}, 1'b1);
    write_word(1, {3'd2, 13'h133}, 1'b1);
    write_word(2, {3'd7, 13'h000}, 1'b1);
    ready_pct = 0;
    run_model();
    pulse_start();
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("abort_in_issue", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expq.delete();
    br_dec.delete();
    pending_branch = 1'b0;
    checkOutput("abort_valid", 32'(instr_valid), 32'd0);
    checkOutput("abort_pc", 32'(pc), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_halted", 32'(halted), 32'd0);
    ready_pct = 100;
    applyStimulus("rerun", 100);

    // Writes and start while busy are ignored; writes in HALT land.
    stall_req = 6;
    run_model();
    pulse_start();
    tick();
    write_word(0, {3'd0, 13'h1FF}, 1'b0);
    pulse_start();
    wait_done("busy_write", 100);
    applyStimulus("after_busy_write", 100);
    write_word(0, {3'd3, 13'h0C3}, 1'b1);
    applyStimulus("halt_write", 100);
    model_mem[0] = {3'd4, 13'h0D4};
    run_model();
    prog_we   = 1'b1;
    prog_addr = 5'd0;
    prog_data = {3'd4, 13'h0D4};
    start     = 1'b1;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    wait_done("write_with_start", 100);

    // Random forward-only programs ending in HALT, random backpressure and outcomes.
    for (int it = 0; it < 8; it++) begin
      len = int'($urandom_range(20, 4));
      for (int a = 0; a < len; a++) begin
        w = {3'($urandom_range(6)), 13'($urandom)};
        if (w[15:13] == 3'd5) begin
          w[4:0] = 5'($urandom_range(((len - a) < 3) ? (len - a) : 3, 1));
        end
        write_word(a, w, 1'b1);
      end
      write_word(len, {3'd7, 13'($urandom)}, 1'b1);
      ready_pct = int'($urandom_range(100, 30));
      applyStimulus("random", 3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
